// File: rtl/spell_trace_capture.sv
// Wand trace capture: maps cursor samples onto a 4x4 box grid, dwell-filters them
// and records visited boxes during a casting window for the trace display stage.
module spell_trace_capture #(
  parameter int GRID_ROW0 = 40,
  parameter int GRID_COL0 = 120,
  parameter int BOX       = 100,
  parameter int DWELL     = 4,
  parameter int TIMEOUT   = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  cursor_row,
  input  logic [9:0]  cursor_col,
  input  logic        cursor_valid,
  input  logic        start,
  input  logic        finish,
  input  logic        clear,
  output logic [15:0] trace,
  output logic        tracing,
  output logic        done,
  output logic        timed_out,
  output logic [4:0]  box_count,
  output logic [3:0]  last_box
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TRACE, DONE} state_t;

  state_t          state, state_d;
  logic            zero_all, set_to, mark_en, hit;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt, dcnt_d;
  logic [3:0]      cand, cand_d;
  logic            s1_valid, s1_in_grid;
  logic [3:0]      s1_box;
  logic [2:0]      rb, cb;

  // Threshold compare per axis: {in_range, band_index}; no divider needed.
  function automatic logic [2:0] band(input logic [31:0] v, input logic [31:0] base);
    logic [31:0] b;
    logic [1:0]  idx;
    b   = 32'(BOX);
    idx = '0;
    for (int unsigned k = 1; k < 4; k++)
      if (v >= base + k * b) idx = 2'(k);
    return {(v >= base) && (v < base + 4 * b), idx};
  endfunction

  assign rb = band(32'(cursor_row), 32'(GRID_ROW0));
  assign cb = band(32'(cursor_col), 32'(GRID_COL0));

  always_comb begin
    state_d  = state;
    zero_all = 1'b0;
    set_to   = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      zero_all = 1'b1;
    end else if (start) begin
      state_d  = TRACE;
      zero_all = 1'b1;
    end else if (state == TRACE) begin
      if (finish) begin
        state_d = DONE;
      end else if (tcnt == T_LAST) begin
        state_d = DONE;
        set_to  = 1'b1;
      end
    end
  end

  // A full grid freezes capture; samples reaching stage 2 outside TRACE are dropped.
  assign mark_en = (state == TRACE) && !zero_all && (box_count != 5'd16);

  always_comb begin
    dcnt_d = dcnt;
    cand_d = cand;
    hit    = 1'b0;
    if (mark_en && s1_valid) begin
      if (!s1_in_grid) begin
        dcnt_d = '0;
      end else if (s1_box != cand) begin
        cand_d = s1_box;
        dcnt_d = DW'(1);
        hit    = (DWELL_MAX == DW'(1));
      end else if (dcnt != DWELL_MAX) begin
        dcnt_d = dcnt + 1'b1;
        hit    = (dcnt_d == DWELL_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      s1_valid   <= 1'b0;
      s1_in_grid <= 1'b0;
      s1_box     <= '0;
      trace      <= '0;
      box_count  <= '0;
      last_box   <= '0;
      timed_out  <= 1'b0;
      tcnt       <= '0;
      dcnt       <= '0;
      cand       <= '0;
    end else begin
      state      <= state_d;
      s1_valid   <= cursor_valid && !zero_all;
      s1_in_grid <= rb[2] && cb[2];
      s1_box     <= {rb[1:0], cb[1:0]};
      if (zero_all) begin
        trace     <= '0;
        box_count <= '0;
        last_box  <= '0;
        timed_out <= 1'b0;
        tcnt      <= '0;
        dcnt      <= '0;
        cand      <= '0;
      end else begin
        if (state == TRACE && state_d == TRACE) tcnt <= tcnt + 1'b1;
        if (set_to) timed_out <= 1'b1;
        dcnt <= dcnt_d;
        cand <= cand_d;
        if (hit) begin
          trace[s1_box] <= 1'b1;
          last_box      <= s1_box;
          if (!trace[s1_box]) box_count <= box_count + 1'b1;
        end
      end
    end
  end

  assign tracing = (state == TRACE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_spell_trace_capture.sv
// Bench for spell_trace_capture: two instances (long and short timeout) share stimulus
// and are checked every cycle against a box-grid model plus literal expectations.
module tb_spell_trace_capture;

  localparam int DWELL = 4;
  localparam int TO_A  = 1000;
  localparam int TO_B  = 50;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  cursor_row;
  logic [9:0]  cursor_col;
  logic        cursor_valid, start, finish, clear;

  logic [15:0] a_trace, b_trace;
  logic        a_tracing, b_tracing, a_done, b_done, a_timed_out, b_timed_out;
  logic [4:0]  a_box_count, b_box_count;
  logic [3:0]  a_last_box, b_last_box;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spell_trace_capture #(.DWELL(DWELL), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .resetn(resetn), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cursor_valid(cursor_valid), .start(start), .finish(finish), .clear(clear),
    .trace(a_trace), .tracing(a_tracing), .done(a_done), .timed_out(a_timed_out),
    .box_count(a_box_count), .last_box(a_last_box));

  spell_trace_capture #(.DWELL(DWELL), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .resetn(resetn), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cursor_valid(cursor_valid), .start(start), .finish(finish), .clear(clear),
    .trace(b_trace), .tracing(b_tracing), .done(b_done), .timed_out(b_timed_out),
    .box_count(b_box_count), .last_box(b_last_box));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: box by plain division, run length of identical in-grid samples
  function automatic int box_of(input int r, input int c);
    if (r < 40 || r >= 440 || c < 120 || c >= 520) return -1;
    return ((r - 40) / 100) * 4 + (c - 120) / 100;
  endfunction

  int          m_state [2];   // 0 idle, 1 trace, 2 done
  logic [15:0] m_trace [2];
  int          m_count [2];
  int          m_last  [2];
  int          m_to    [2];
  int          m_tcnt  [2];
  int          run_box [2];
  int          run_len [2];
  int          p_valid [2];
  int          p_box   [2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0; m_trace[i] = '0; m_count[i] = 0; m_last[i] = 0; m_to[i] = 0;
        m_tcnt[i] = 0; run_box[i] = 0; run_len[i] = 0; p_valid[i] = 0; p_box[i] = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int lim;
        int z;
        lim = (i == 0) ? TO_A : TO_B;
        z   = (clear || start) ? 1 : 0;
        if (z == 0 && m_state[i] == 1 && p_valid[i] != 0 && m_count[i] < 16) begin
          if (p_box[i] < 0) run_len[i] = 0;
          else begin
            if (p_box[i] == run_box[i]) run_len[i]++;
            else begin run_box[i] = p_box[i]; run_len[i] = 1; end
            if (run_len[i] == DWELL) begin
              if (m_trace[i][p_box[i]] == 1'b0) m_count[i]++;
              m_trace[i][p_box[i]] = 1'b1;
              m_last[i] = p_box[i];
            end
          end
        end
        if (z != 0) begin
          m_state[i] = clear ? 0 : 1;
          m_trace[i] = '0; m_count[i] = 0; m_last[i] = 0; m_to[i] = 0;
          m_tcnt[i] = 0; run_box[i] = 0; run_len[i] = 0;
        end else if (m_state[i] == 1) begin
          if (finish) m_state[i] = 2;
          else if (m_tcnt[i] == lim - 1) begin m_state[i] = 2; m_to[i] = 1; end
          else m_tcnt[i]++;
        end
        p_valid[i] = (cursor_valid && z == 0) ? 1 : 0;
        p_box[i]   = box_of(int'(cursor_row), int'(cursor_col));
      end
    end
  end

  always @(negedge clk) begin
    chk("a_trace", a_trace, m_trace[0]);
    chk("a_tracing", a_tracing, m_state[0] == 1);
    chk("a_done", a_done, m_state[0] == 2);
    chk("a_timed_out", a_timed_out, m_to[0]);
    chk("a_box_count", a_box_count, m_count[0]);
    chk("a_last_box", a_last_box, m_last[0]);
    chk("b_trace", b_trace, m_trace[1]);
    chk("b_tracing", b_tracing, m_state[1] == 1);
    chk("b_done", b_done, m_state[1] == 2);
    chk("b_timed_out", b_timed_out, m_to[1]);
    chk("b_box_count", b_box_count, m_count[1]);
    chk("b_last_box", b_last_box, m_last[1]);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic samp(input int r, input int c, input int n);
    repeat (n) begin
      @(negedge clk);
      cursor_row = 9'(r); cursor_col = 10'(c); cursor_valid = 1'b1;
    end
    @(negedge clk);
    cursor_valid = 1'b0;
  endtask

  task automatic samp_box(input int b);
    samp(90 + 100 * (b / 4), 170 + 100 * (b % 4), DWELL);
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_finish;
    @(negedge clk); finish = 1'b1;
    @(negedge clk); finish = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cursor_row = '0; cursor_col = '0;
    cursor_valid = 1'b0; start = 1'b0; finish = 1'b0; clear = 1'b0;
    wait_cyc(3);
    chk("lit_rst_trace", a_trace, 0);
    chk("lit_rst_tracing", a_tracing, 0);
    chk("lit_rst_done", a_done, 0);
    chk("lit_rst_count", a_box_count, 0);
    chk("lit_rst_last", a_last_box, 0);
    resetn = 1'b1;

    samp(90, 170, 4); wait_cyc(2);
    chk("lit_idle_trace", a_trace, 0);
    chk("lit_idle_count", a_box_count, 0);
    chk("lit_idle_tracing", a_tracing, 0);

    pulse_start; samp(90, 170, 4); wait_cyc(2);
    chk("lit_dwell_trace", a_trace, 16'h0001);
    chk("lit_dwell_count", a_box_count, 1);
    chk("lit_dwell_last", a_last_box, 0);
    chk("lit_dwell_tracing", a_tracing, 1);

    pulse_start; samp(90, 170, 3); samp(90, 270, 1); wait_cyc(2);
    chk("lit_short_trace", a_trace, 0);

    pulse_start;
    samp_box(0); samp_box(5); samp_box(10); samp_box(15); wait_cyc(2);
    chk("lit_diag_trace", a_trace, 16'h8421);
    chk("lit_diag_count", a_box_count, 4);
    chk("lit_diag_last", a_last_box, 15);
    pulse_finish; wait_cyc(2);
    chk("lit_diag_done", a_done, 1);
    chk("lit_diag_hold", a_trace, 16'h8421);

    pulse_start;
    samp(39, 170, 4); samp(440, 170, 4); samp(90, 119, 4); samp(90, 520, 4); wait_cyc(2);
    chk("lit_oog_trace", a_trace, 0);
    samp(40, 120, 4); wait_cyc(2);
    chk("lit_corner0", a_trace, 16'h0001);
    samp(439, 519, 4); wait_cyc(2);
    chk("lit_corner15", a_trace, 16'h8001);
    chk("lit_corner15_last", a_last_box, 15);

    pulse_start; samp_box(1); samp_box(2); samp_box(1); wait_cyc(2);
    chk("lit_revisit_trace", a_trace, 16'h0006);
    chk("lit_revisit_count", a_box_count, 2);
    chk("lit_revisit_last", a_last_box, 1);

    pulse_start;
    for (int b = 0; b < 16; b++) samp_box(b);
    wait_cyc(2);
    chk("lit_full_trace", a_trace, 16'hFFFF);
    chk("lit_full_count", a_box_count, 16);
    chk("lit_full_tracing", a_tracing, 1);

    pulse_start; wait_cyc(49);
    chk("lit_to_before", b_done, 0);
    wait_cyc(1);
    chk("lit_to_done", b_done, 1);
    chk("lit_to_flag", b_timed_out, 1);
    chk("lit_to_a_tracing", a_tracing, 1);

    samp(90, 470, 4); wait_cyc(2);
    chk("lit_pre_restart", a_trace, 16'h0008);
    @(negedge clk); start = 1'b1; finish = 1'b1;
    @(negedge clk); start = 1'b0; finish = 1'b0;
    wait_cyc(1);
    chk("lit_restart_trace", a_trace, 0);
    chk("lit_restart_tracing", a_tracing, 1);

    pulse_finish; wait_cyc(1);
    chk("lit_fin_done", a_done, 1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    wait_cyc(1);
    chk("lit_clear_trace", a_trace, 0);
    chk("lit_clear_tracing", a_tracing, 0);
    chk("lit_clear_done", a_done, 0);

    pulse_start; samp(190, 270, 4); wait_cyc(2);
    chk("lit_mid_trace", a_trace, 16'h0020);
    #2 resetn = 1'b0;
    #1;
    chk("lit_abort_trace", a_trace, 0);
    chk("lit_abort_tracing", a_tracing, 0);
    chk("lit_abort_count", a_box_count, 0);
    @(negedge clk); resetn = 1'b1;
    wait_cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
